// File: rtl/wbu_stage.sv
// -----------------------------------------------------------------------------
// wbu_stage -- write-back unit, last stage of the core pipeline.
//
// This stage selects the value to write back to the GPR file. The value comes
// from the ALU result, the LSU load data or the link address (PC + 4), as chosen
// by the IDU source field. The stage registers the GPR write request for one
// cycle before it reaches the register file.
//
// Ports:
//   i_sys_clk            clock, rising edge
//   i_sys_rst_n          asynchronous active-low reset
//   i_sys_ready          upstream presents a valid result this cycle
//   o_sys_valid          registered write-back request valid
//   i_idu_ctr_reg_wr_en  instruction writes a GPR
//   i_idu_ctr_reg_wr_src write-back source select (REG_WR_SRC_* codes)
//   i_ifu_pc             instruction PC
//   i_exu_res            ALU result
//   i_ram_res            load data (already extended)
//   i_gpr_wr_id          destination register index
//   o_wbu_gpr_wr_en      GPR write enable
//   o_wbu_gpr_wr_id      GPR write index
//   o_wbu_gpr_wr_data    GPR write data
//
// Build option:
//   WBU_X0_FILTER_EN  when defined, a request targeting x0 registers with the
//                     write enable cleared. Id and data are still latched.
//                     When undefined, the register file must drop x0 writes.
//
// ARGS_WIDTH and REG_WR_SRC_* normally come from the shared cfg.sv. The
// fallbacks below let this file stand alone. They match cfg.sv encodings, in
// which code 0 is not a legal source.
// -----------------------------------------------------------------------------
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 2
`endif
`ifndef REG_WR_SRC_ALU
`define REG_WR_SRC_ALU 2'd1
`endif
`ifndef REG_WR_SRC_MEM
`define REG_WR_SRC_MEM 2'd2
`endif
`ifndef REG_WR_SRC_PC
`define REG_WR_SRC_PC 2'd3
`endif

module wbu_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst_n,
    input  logic                   i_sys_ready,
    output logic                   o_sys_valid,
    input  logic                   i_idu_ctr_reg_wr_en,
    input  logic [`ARGS_WIDTH-1:0] i_idu_ctr_reg_wr_src,
    input  logic [DATA_WIDTH-1:0]  i_ifu_pc,
    input  logic [DATA_WIDTH-1:0]  i_exu_res,
    input  logic [DATA_WIDTH-1:0]  i_ram_res,
    input  logic [4:0]             i_gpr_wr_id,
    output logic                   o_wbu_gpr_wr_en,
    output logic [4:0]             o_wbu_gpr_wr_id,
    output logic [DATA_WIDTH-1:0]  o_wbu_gpr_wr_data
);

    localparam logic [DATA_WIDTH-1:0] LINK_OFFSET = DATA_WIDTH'(4);

    logic                  src_legal_p0;
    logic [DATA_WIDTH-1:0] wr_data_p0;
    logic                  wr_en_p0;

    logic                  vld_p1;
    logic                  wr_en_p1;
    logic [4:0]            wr_id_p1;
    logic [DATA_WIDTH-1:0] wr_data_p1;

    // ---- p0: source select and enable qualification (combinational) ----
    always_comb begin
        src_legal_p0 = 1'b1;
        wr_data_p0   = '0;
        case (i_idu_ctr_reg_wr_src)
            `REG_WR_SRC_ALU: wr_data_p0 = i_exu_res;
            `REG_WR_SRC_MEM: wr_data_p0 = i_ram_res;
            // The link address wraps modulo 2^DATA_WIDTH, and the carry is dropped.
            `REG_WR_SRC_PC:  wr_data_p0 = i_ifu_pc + LINK_OFFSET;
            default:         src_legal_p0 = 1'b0;
        endcase
    end

`ifdef WBU_X0_FILTER_EN
    assign wr_en_p0 = i_sys_ready & i_idu_ctr_reg_wr_en & src_legal_p0 &
                      (i_gpr_wr_id != 5'd0);
`else
    assign wr_en_p0 = i_sys_ready & i_idu_ctr_reg_wr_en & src_legal_p0;
`endif

    // ---- p1: registered write request ----
    // Id and data hold while idle, so the register file sees a stable bus.
    // Valid and enable drop on any cycle that has no upstream result.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            vld_p1     <= 1'b0;
            wr_en_p1   <= 1'b0;
            wr_id_p1   <= '0;
            wr_data_p1 <= '0;
        end else if (i_sys_ready) begin
            vld_p1     <= 1'b1;
            wr_en_p1   <= wr_en_p0;
            wr_id_p1   <= i_gpr_wr_id;
            wr_data_p1 <= wr_data_p0;
        end else begin
            vld_p1     <= 1'b0;
            wr_en_p1   <= 1'b0;
        end
    end

    assign o_sys_valid       = vld_p1;
    assign o_wbu_gpr_wr_en   = wr_en_p1;
    assign o_wbu_gpr_wr_id   = wr_id_p1;
    assign o_wbu_gpr_wr_data = wr_data_p1;

endmodule

// File: tb/tb_wbu_stage.sv
// -----------------------------------------------------------------------------
// tb_wbu_stage -- directed, table-driven bench for wbu_stage.
// -----------------------------------------------------------------------------
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 2
`endif
`ifndef REG_WR_SRC_ALU
`define REG_WR_SRC_ALU 2'd1
`endif
`ifndef REG_WR_SRC_MEM
`define REG_WR_SRC_MEM 2'd2
`endif
`ifndef REG_WR_SRC_PC
`define REG_WR_SRC_PC 2'd3
`endif

module tb_wbu_stage;

    localparam logic [`ARGS_WIDTH-1:0] SRC_ALU = `REG_WR_SRC_ALU;
    localparam logic [`ARGS_WIDTH-1:0] SRC_MEM = `REG_WR_SRC_MEM;
    localparam logic [`ARGS_WIDTH-1:0] SRC_PC  = `REG_WR_SRC_PC;
    localparam logic [`ARGS_WIDTH-1:0] SRC_BAD = '0;
`ifdef WBU_X0_FILTER_EN
    localparam logic X0_EN = 1'b0;
`else
    localparam logic X0_EN = 1'b1;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   ready;
    logic                   valid;
    logic                   wr_en_in;
    logic [`ARGS_WIDTH-1:0] src;
    logic [31:0]            pc, exu, ram;
    logic [4:0]             id_in;
    logic                   wr_en;
    logic [4:0]             wr_id;
    logic [31:0]            wr_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wbu_stage #(.DATA_WIDTH(32)) dut (
        .i_sys_clk            (clk),
        .i_sys_rst_n          (rst_n),
        .i_sys_ready          (ready),
        .o_sys_valid          (valid),
        .i_idu_ctr_reg_wr_en  (wr_en_in),
        .i_idu_ctr_reg_wr_src (src),
        .i_ifu_pc             (pc),
        .i_exu_res            (exu),
        .i_ram_res            (ram),
        .i_gpr_wr_id          (id_in),
        .o_wbu_gpr_wr_en      (wr_en),
        .o_wbu_gpr_wr_id      (wr_id),
        .o_wbu_gpr_wr_data    (wr_data)
    );

    typedef struct {
        logic                   ready;
        logic                   wr_en;
        logic [`ARGS_WIDTH-1:0] src;
        logic [31:0]            pc;
        logic [31:0]            exu;
        logic [31:0]            ram;
        logic [4:0]             id;
        logic                   e_vld;
        logic                   e_en;
        logic [4:0]             e_id;
        logic [31:0]            e_data;
    } vec_t;

    vec_t vec [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ready    = v.ready;
        wr_en_in = v.wr_en;
        src      = v.src;
        pc       = v.pc;
        exu      = v.exu;
        ram      = v.ram;
        id_in    = v.id;
    endtask

    task automatic chk_out(input string tag, input logic e_vld, input logic e_en,
                           input logic [4:0] e_id, input logic [31:0] e_data);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_vld});
        chk({tag, ".wr_en"}, {31'd0, wr_en}, {31'd0, e_en});
        chk({tag, ".wr_id"}, {27'd0, wr_id}, {27'd0, e_id});
        chk({tag, ".wr_data"}, wr_data, e_data);
    endtask

    initial begin
        // Each row's expectation follows from the previous row when ready=0,
        // because id and data hold.
        vec[0] = '{1'b1, 1'b1, SRC_ALU, 32'h8000_0000, 32'h1, 32'h2, 5'd1,
                   1'b1, 1'b1, 5'd1, 32'h1};
        vec[1] = '{1'b1, 1'b1, SRC_MEM, 32'h8000_0000, 32'h1, 32'h2, 5'd2,
                   1'b1, 1'b1, 5'd2, 32'h2};
        vec[2] = '{1'b1, 1'b1, SRC_PC, 32'h8000_0000, 32'h1, 32'h2, 5'd3,
                   1'b1, 1'b1, 5'd3, 32'h8000_0004};
        vec[3] = '{1'b1, 1'b1, SRC_PC, 32'hFFFF_FFFC, 32'h1, 32'h2, 5'd4,
                   1'b1, 1'b1, 5'd4, 32'h0};
        vec[4] = '{1'b1, 1'b0, SRC_ALU, 32'h8000_0000, 32'h1, 32'h2, 5'd5,
                   1'b1, 1'b0, 5'd5, 32'h1};
        vec[5] = '{1'b0, 1'b1, SRC_ALU, 32'h8000_0000, 32'h55, 32'h2, 5'd7,
                   1'b0, 1'b0, 5'd5, 32'h1};
        vec[6] = '{1'b1, 1'b1, SRC_BAD, 32'h8000_0000, 32'h1, 32'h2, 5'd6,
                   1'b1, 1'b0, 5'd6, 32'h0};
        vec[7] = '{1'b1, 1'b1, SRC_ALU, 32'h8000_0000, 32'hDEAD_BEEF, 32'h2, 5'd0,
                   1'b1, X0_EN, 5'd0, 32'hDEAD_BEEF};
        vec[8] = '{1'b0, 1'b1, SRC_MEM, 32'h0, 32'h0, 32'h0, 5'd9,
                   1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF};
        vec[9] = '{1'b1, 1'b1, SRC_MEM, 32'h0, 32'h0, 32'h1234_5678, 5'd31,
                   1'b1, 1'b1, 5'd31, 32'h1234_5678};

        // Reset held for several clock edges while ready=1 and the inputs are
        // busy: the outputs must stay at zero.
        rst_n = 1'b0;
        drive('{1'b1, 1'b1, SRC_ALU, 32'h0, 32'hA5, 32'h0, 5'd9,
                1'b0, 1'b0, 5'd0, 32'h0});
        repeat (3) @(posedge clk);
        #1 chk_out("reset", 1'b0, 1'b0, 5'd0, 32'h0);

        // The first edge after release produces valid outputs.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk_out("first", 1'b1, 1'b1, 5'd9, 32'hA5);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vec[i]);
            @(posedge clk);
            #1 chk_out($sformatf("vec%0d", i), vec[i].e_vld, vec[i].e_en,
                       vec[i].e_id, vec[i].e_data);
        end

        // Reset asserted mid-cycle while valid=1 must clear the outputs
        // with no clock edge.
        #2 rst_n = 1'b0;
        #1 chk_out("async_rst", 1'b0, 1'b0, 5'd0, 32'h0);

        // After release the stage produces results again.
        @(negedge clk);
        rst_n = 1'b1;
        drive('{1'b1, 1'b1, SRC_PC, 32'h100, 32'h0, 32'h0, 5'd10,
                1'b0, 1'b0, 5'd0, 32'h0});
        @(posedge clk);
        #1 chk_out("recover", 1'b1, 1'b1, 5'd10, 32'h104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
